// File: rtl/prog_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_timer_if
// Purpose  : Control/status bundle between an owning FSM and prog_timer.
// Revision : 1.0 - initial release
// ============================================================================
interface prog_timer_if #(
    parameter int WIDTH = 7,
    parameter int PRE_W = 4
);
    logic [WIDTH-1:0] period;
    logic [PRE_W-1:0] prescale;
    logic             mode;
    logic             start;
    logic             stop;
    logic             ack;
    logic             trigger;
    logic             irq;
    logic             overrun;
    logic             running;
    logic [WIDTH-1:0] time_remaining;

    modport master (
        output period, prescale, mode, start, stop, ack,
        input  trigger, irq, overrun, running, time_remaining
    );

    modport slave (
        input  period, prescale, mode, start, stop, ack,
        output trigger, irq, overrun, running, time_remaining
    );
endinterface
`default_nettype wire

// File: rtl/prog_timer.sv
`default_nettype none
// ============================================================================
// Module   : prog_timer
// Purpose  : Prescaled down-counting timer, one-shot/periodic, sticky irq.
// Revision : 1.0 - initial release
// ============================================================================
module prog_timer #(
    parameter int WIDTH = 7,
    parameter int PRE_W = 4
) (
    input  wire logic    clock_i,
    input  wire logic    reset_ni,
    prog_timer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] per_q, per_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PRE_W-1:0] div_q, div_d;
    logic             mode_q, mode_d;
    logic             trig_q, trig_d;
    logic             irq_q, irq_d;
    logic             ovr_q, ovr_d;
    logic             run_q, run_d;
    logic             expiry;

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            count_q <= '0;
            per_q   <= '0;
            pre_q   <= '0;
            div_q   <= '0;
            mode_q  <= 1'b0;
            trig_q  <= 1'b0;
            irq_q   <= 1'b0;
            ovr_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            per_q   <= per_d;
            pre_q   <= pre_d;
            div_q   <= div_d;
            mode_q  <= mode_d;
            trig_q  <= trig_d;
            irq_q   <= irq_d;
            ovr_q   <= ovr_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        per_d   = per_q;
        pre_d   = pre_q;
        div_d   = div_q;
        mode_d  = mode_q;
        irq_d   = irq_q;
        ovr_d   = ovr_q;
        expiry  = 1'b0;

        // start wins over stop and over any tick in the same cycle
        if (bus.start) begin
            per_d   = bus.period;
            div_d   = bus.prescale;
            mode_d  = bus.mode;
            count_d = bus.period;
            pre_d   = '0;
            state_d = RUN;
        end else if (state_q == RUN) begin
            if (bus.stop) begin
                state_d = IDLE;
            end else if (pre_q == div_q) begin
                pre_d = '0;
                if (count_q == '0) begin
                    expiry = 1'b1;
                    if (mode_q) begin
                        count_d = per_q;
                    end else begin
                        state_d = EXPIRED;
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end

        if (bus.ack) begin
            irq_d = 1'b0;
            ovr_d = 1'b0;
        end
        // a coincident ack suppresses overrun but cannot suppress irq
        if (expiry) begin
            irq_d = 1'b1;
            if (irq_q && !bus.ack) begin
                ovr_d = 1'b1;
            end
        end

        trig_d = expiry;
        run_d  = (state_d == RUN);
    end

    assign bus.trigger        = trig_q;
    assign bus.irq            = irq_q;
    assign bus.overrun        = ovr_q;
    assign bus.running        = run_q;
    assign bus.time_remaining = count_q;
endmodule
`default_nettype wire

// File: tb/tb_prog_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_timer
// Purpose  : Directed self-checking bench for prog_timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_timer;
    localparam int WIDTH = 7;
    localparam int PRE_W = 4;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;
    int   trig_seen;

    prog_timer_if #(.WIDTH(WIDTH), .PRE_W(PRE_W)) bus ();

    prog_timer #(.WIDTH(WIDTH), .PRE_W(PRE_W)) u_dut (
        .clock_i  (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse(input int p, input int d, input int m, input logic with_stop);
        bus.period   = p[WIDTH-1:0];
        bus.prescale = d[PRE_W-1:0];
        bus.mode     = m[0];
        bus.start    = 1'b1;
        bus.stop     = with_stop;
        step();
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_trig"}, bus.trigger, 0);
        chk({tag, "_irq"},  bus.irq, 0);
        chk({tag, "_ovr"},  bus.overrun, 0);
        chk({tag, "_run"},  bus.running, 0);
        chk({tag, "_tr"},   bus.time_remaining, 0);
    endtask

    initial begin
        n_total      = 0;
        n_bad        = 0;
        rst_n        = 1'b0;
        bus.period   = '0;
        bus.prescale = '0;
        bus.mode     = 1'b0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.ack      = 1'b0;

        // reset and idle
        step();
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("idle_tr", bus.time_remaining, 0);
            chk("idle_trig", bus.trigger, 0);
        end

        // periodic P=4 D=0
        start_pulse(4, 0, 1, 1'b0);
        chk("per_tr0", bus.time_remaining, 4);
        chk("per_run0", bus.running, 1);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("per_tr", bus.time_remaining, 4 - (k % 5));
            chk("per_trig", bus.trigger, (k % 5 == 0) ? 1 : 0);
            chk("per_irq", bus.irq, (k >= 5) ? 1 : 0);
            chk("per_ovr", bus.overrun, (k >= 10) ? 1 : 0);
        end
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        chk("ack_irq", bus.irq, 0);
        chk("ack_ovr", bus.overrun, 0);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("stop_run", bus.running, 0);

        // prescaled one-shot P=2 D=3
        start_pulse(2, 3, 0, 1'b0);
        chk("os_tr0", bus.time_remaining, 2);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("os_tr", bus.time_remaining, (k < 12) ? (2 - k / 4) : 0);
            chk("os_trig", bus.trigger, (k == 12) ? 1 : 0);
            chk("os_run", bus.running, (k < 12) ? 1 : 0);
        end
        trig_seen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (bus.trigger) trig_seen++;
        end
        chk("os_no_retrig", trig_seen, 0);
        chk("os_tr_hold", bus.time_remaining, 0);
        chk("os_irq", bus.irq, 1);

        // overrun and ack, periodic P=1 D=0
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        chk("clr_irq", bus.irq, 0);
        start_pulse(1, 0, 1, 1'b0);
        step();
        step();
        chk("ov_trig1", bus.trigger, 1);
        chk("ov_irq1", bus.irq, 1);
        chk("ov_ovr1", bus.overrun, 0);
        step();
        step();
        chk("ov_trig2", bus.trigger, 1);
        chk("ov_ovr2", bus.overrun, 1);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        chk("ov_ack_irq", bus.irq, 0);
        chk("ov_ack_ovr", bus.overrun, 0);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        chk("ov_coin_trig", bus.trigger, 1);
        chk("ov_coin_irq", bus.irq, 1);
        chk("ov_coin_ovr", bus.overrun, 0);
        step();
        step();
        chk("ov_again", bus.overrun, 1);

        // stop and restart
        start_pulse(10, 0, 0, 1'b0);
        for (int k = 0; k < 7; k++) step();
        chk("sr_tr3", bus.time_remaining, 3);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("sr_stop_tr", bus.time_remaining, 3);
        chk("sr_stop_run", bus.running, 0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("sr_frozen", bus.time_remaining, 3);
        end
        start_pulse(6, 0, 0, 1'b1);
        chk("sr_ss_tr", bus.time_remaining, 6);
        chk("sr_ss_run", bus.running, 1);
        step();
        step();
        chk("sr_cnt", bus.time_remaining, 4);
        start_pulse(9, 0, 0, 1'b0);
        chk("sr_reload", bus.time_remaining, 9);

        // P=0 periodic: trigger every cycle
        start_pulse(0, 0, 1, 1'b0);
        chk("p0_trig0", bus.trigger, 0);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("p0_trig", bus.trigger, 1);
            chk("p0_tr", bus.time_remaining, 0);
        end

        // full-scale one-shot, no wrap
        start_pulse(127, 0, 0, 1'b0);
        chk("max_tr0", bus.time_remaining, 127);
        for (int k = 1; k <= 127; k++) begin
            step();
            if (k % 32 == 0 || k == 127)
                chk("max_tr", bus.time_remaining, 127 - k);
        end
        chk("max_trig_pre", bus.trigger, 0);
        step();
        chk("max_trig", bus.trigger, 1);
        chk("max_run", bus.running, 0);
        step();
        chk("max_nowrap", bus.time_remaining, 0);

        // reset mid-count overrides a coincident start
        start_pulse(50, 0, 1, 1'b0);
        for (int k = 0; k < 5; k++) step();
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.ack   = 1'b1;
        step();
        bus.start = 1'b0;
        bus.ack   = 1'b0;
        chk_all_zero("midrst");
        rst_n = 1'b1;
        step();
        chk("post_rst_run", bus.running, 0);
        chk("post_rst_tr", bus.time_remaining, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
